// File: rtl/mmio_stream_bridge.sv
// mmio_stream_bridge
//
// Memory-mapped bridge between a core's MEM stage and a pair of valid/ready
// streams. Stores to TX_DATA queue words toward the outbound stream. Words
// arriving on the inbound stream queue up for the core to read and pop.
//
// Register map. The map is selected when mem_addr[9:8] != 0. The offset is
// mem_addr[7:3], and mem_addr[2:0] is ignored.
//   0x00 STATUS   RO/W1C  [3:0] tx_count, [7:4] rx_count (saturate at 15),
//                         [8] tx_full, [9] rx_empty,
//                         [16] tx_ovf, [17] rx_unf (sticky, write 1 to clear)
//   0x08 TX_DATA  WO      push mem_wdata into the TX FIFO
//   0x10 RX_DATA  RO      RX head without popping (0 when empty)
//   0x18 RX_POP   WO      any write pops the RX head
//   0x20 SCRATCH  RW      D_WIDTH-wide general-purpose register
//   0x28 CYCLES   RO      free-running cycle counter, only present when the
//                         macro MMIO_CYCLE_COUNTER_EN is defined; otherwise
//                         reads 0
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   mem_addr/wdata/we     core access in the MEM stage
//   mem_rdata             load data, registered (one-cycle latency)
//   tx_data/valid/ready   outbound stream (bridge is the source)
//   rx_data/valid/ready   inbound stream (bridge is the sink)
//
// Parameters
//   D_WIDTH     data width of the core bus and of both streams (>= 18 so
//               every STATUS bit fits)
//   FIFO_DEPTH  entries per FIFO, a power of two, at least 2

module mmio_stream_bridge #(
  parameter int D_WIDTH    = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         mem_addr,
  input  logic [D_WIDTH-1:0] mem_wdata,
  input  logic               mem_we,
  output logic [D_WIDTH-1:0] mem_rdata,
  output logic [D_WIDTH-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [D_WIDTH-1:0] rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [4:0] OFF_STATUS  = 5'h00;
  localparam logic [4:0] OFF_TX_DATA = 5'h01;
  localparam logic [4:0] OFF_RX_DATA = 5'h02;
  localparam logic [4:0] OFF_RX_POP  = 5'h03;
  localparam logic [4:0] OFF_SCRATCH = 5'h04;
`ifdef MMIO_CYCLE_COUNTER_EN
  localparam logic [4:0] OFF_CYCLES  = 5'h05;
`endif

  // Counts are reported in 4-bit STATUS fields. Deeper FIFOs pin the field
  // at 15 instead of wrapping.
  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (int'(c) > 15) return 4'hF;
    return 4'(c);
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       is_mmio;
  logic [4:0] reg_off;
  logic       wr_en;
  logic       status_wr;
  logic       unused_addr_lsb;

  assign is_mmio         = |mem_addr[9:8];
  assign reg_off         = mem_addr[7:3];
  assign wr_en           = mem_we & is_mmio & ~reset;
  assign status_wr       = wr_en && (reg_off == OFF_STATUS);
  assign unused_addr_lsb = ^mem_addr[2:0];

  // ---------------------------------------------------------------------------
  // TX FIFO (core -> stream)
  // ---------------------------------------------------------------------------
  logic [D_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]      tx_wptr;
  logic [PW-1:0]      tx_rptr;
  logic [CW-1:0]      tx_count;
  logic               tx_full;
  logic               tx_empty;
  logic               tx_push_req;
  logic               tx_push;
  logic               tx_pop;

  assign tx_full     = (tx_count == DEPTH_C);
  assign tx_empty    = (tx_count == '0);
  assign tx_push_req = wr_en && (reg_off == OFF_TX_DATA);
  // Fullness is judged on pre-edge state, so a push that meets a full FIFO
  // is dropped even when the stream drains an entry on the same edge.
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && tx_ready && !reset;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Storage carries no reset. The pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (stream -> core)
  // ---------------------------------------------------------------------------
  logic [D_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]      rx_wptr;
  logic [PW-1:0]      rx_rptr;
  logic [CW-1:0]      rx_count;
  logic               rx_full;
  logic               rx_empty;
  logic               rx_pop_req;
  logic               rx_pop;
  logic               rx_push;

  assign rx_full    = (rx_count == DEPTH_C);
  assign rx_empty   = (rx_count == '0);
  assign rx_pop_req = wr_en && (reg_off == OFF_RX_POP);
  assign rx_pop     = rx_pop_req && !rx_empty;
  assign rx_push    = rx_valid && !rx_full && !reset;

  assign rx_ready = !rx_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags, SCRATCH and the optional cycle counter
  // ---------------------------------------------------------------------------
  logic               tx_ovf;
  logic               rx_unf;
  logic [D_WIDTH-1:0] scratch;

  // A set event takes priority over a W1C clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_push_req && tx_full)        tx_ovf <= 1'b1;
      else if (status_wr && mem_wdata[16]) tx_ovf <= 1'b0;

      if (rx_pop_req && rx_empty)        rx_unf <= 1'b1;
      else if (status_wr && mem_wdata[17]) rx_unf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_en && (reg_off == OFF_SCRATCH)) begin
      scratch <= mem_wdata;
    end
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [D_WIDTH-1:0] cycles;

  always_ff @(posedge clk) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux and registered load data
  // ---------------------------------------------------------------------------
  logic [D_WIDTH-1:0] status_word;
  logic [D_WIDTH-1:0] rdata_nxt;

  always_comb begin
    status_word      = '0;
    status_word[3:0] = sat_count(tx_count);
    status_word[7:4] = sat_count(rx_count);
    status_word[8]   = tx_full;
    status_word[9]   = rx_empty;
    status_word[16]  = tx_ovf;
    status_word[17]  = rx_unf;
  end

  // Write-only and unmapped offsets fall through to the zero default.
  always_comb begin
    rdata_nxt = '0;
    if (is_mmio) begin
      case (reg_off)
        OFF_STATUS:  rdata_nxt = status_word;
        OFF_RX_DATA: if (!rx_empty) rdata_nxt = rx_mem[rx_rptr];
        OFF_SCRATCH: rdata_nxt = scratch;
`ifdef MMIO_CYCLE_COUNTER_EN
        OFF_CYCLES:  rdata_nxt = cycles;
`endif
        default:     rdata_nxt = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load-data register: value selected this cycle appears next cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) mem_rdata <= '0;
    else       mem_rdata <= rdata_nxt;
  end

endmodule

// File: tb/tb_mmio_stream_bridge.sv
`timescale 1ns/1ps
module tb_mmio_stream_bridge;

  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  mmio_stream_bridge #(.D_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: queues stand in for the FIFOs.
  logic [DW-1:0] m_txq[$];
  logic [DW-1:0] m_rxq[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_scratch;
  logic [DW-1:0] m_cycles;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] seen_tx[$];

  function automatic logic [DW-1:0] m_read(input logic [9:0] a);
    int tc;
    int rc;
    logic [DW-1:0] v;
    v = '0;
    if (a[9:8] == 2'b00) return '0;
    case (a[7:3])
      5'd0: begin
        tc = (m_txq.size() > 15) ? 15 : m_txq.size();
        rc = (m_rxq.size() > 15) ? 15 : m_rxq.size();
        v = 64'(tc) | (64'(rc) << 4) | (64'(m_txq.size() == DEPTH) << 8) |
            (64'(m_rxq.size() == 0) << 9) | (64'(m_ovf) << 16) | (64'(m_unf) << 17);
      end
      5'd2: v = (m_rxq.size() != 0) ? m_rxq[0] : '0;
      5'd4: v = m_scratch;
`ifdef MMIO_CYCLE_COUNTER_EN
      5'd5: v = m_cycles;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance model and DUT by one clock; inputs must already be set.
  task automatic cycle();
    logic [DW-1:0] nxt;
    bit wr, txf, rxe, txp, rxp;
    logic [4:0] off;
    if (!reset && tx_valid && tx_ready) seen_tx.push_back(tx_data);
    if (reset) begin
      m_txq.delete();
      m_rxq.delete();
      m_ovf = 0; m_unf = 0;
      m_scratch = '0; m_cycles = '0; m_rdata = '0;
    end else begin
      nxt = m_read(mem_addr);
      wr  = mem_we && (mem_addr[9:8] != 2'b00);
      off = mem_addr[7:3];
      txf = (m_txq.size() == DEPTH);
      rxe = (m_rxq.size() == 0);
      txp = (m_txq.size() != 0) && tx_ready;
      rxp = rx_valid && (m_rxq.size() < DEPTH);
      if (wr && off == 5'd0) begin
        if (mem_wdata[16]) m_ovf = 0;
        if (mem_wdata[17]) m_unf = 0;
      end
      if (txp) void'(m_txq.pop_front());
      if (wr && off == 5'd1) begin
        if (txf) m_ovf = 1;
        else m_txq.push_back(mem_wdata);
      end
      if (wr && off == 5'd3) begin
        if (rxe) m_unf = 1;
        else void'(m_rxq.pop_front());
      end
      if (rxp) m_rxq.push_back(rx_data);
      if (wr && off == 5'd4) m_scratch = mem_wdata;
      m_cycles = m_cycles + 1;
      m_rdata = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [9:0] a, input logic [DW-1:0] d, input logic we);
    mem_addr = a; mem_wdata = d; mem_we = we;
  endtask

  task automatic do_reset();
    reset = 1; put(10'h000, '0, 0);
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    cycle();
    reset = 0;
    seen_tx.delete();
  endtask

  task automatic test_reset();
    reset = 1; put(10'h108, 64'hDEAD, 1);
    rx_valid = 1; rx_data = 64'h5; tx_ready = 1;
    cycle(); cycle();
    n_cmp++; if (mem_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", mem_rdata); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
    reset = 0; rx_valid = 0; tx_ready = 0;
    put(10'h100, '0, 0);
    cycle();
    n_cmp++; if (mem_rdata !== 64'h200) begin n_fail++; $display("FAIL reset_status got %h exp 200", mem_rdata); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_tx_valid got %b exp 0", tx_valid); end
  endtask

  task automatic test_tx_basic();
    do_reset();
    put(10'h108, 64'hA5, 1); cycle();
    put(10'h108, 64'h5A, 1); cycle();
    put(10'h100, '0, 0);
    n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL txb_valid got %b exp 1", tx_valid); end
    n_cmp++; if (tx_data !== 64'hA5) begin n_fail++; $display("FAIL txb_head got %h exp a5", tx_data); end
    cycle();
    n_cmp++; if (mem_rdata !== 64'h202) begin n_fail++; $display("FAIL txb_status got %h exp 202", mem_rdata); end
    seen_tx.delete();
    tx_ready = 1; cycle(); cycle(); tx_ready = 0;
    n_cmp++;
    if (seen_tx.size() != 2) begin n_fail++; $display("FAIL txb_count got %0d exp 2", seen_tx.size()); end
    else if (seen_tx[0] !== 64'hA5 || seen_tx[1] !== 64'h5A) begin
      n_fail++; $display("FAIL txb_order got %h,%h exp a5,5a", seen_tx[0], seen_tx[1]);
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL txb_drained got %b exp 0", tx_valid); end
  endtask

  task automatic test_tx_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin put(10'h108, 64'(32'h100 + i), 1); cycle(); end
    put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h10308) begin n_fail++; $display("FAIL ovf_status got %h exp 10308", mem_rdata); end
    put(10'h100, 64'h10000, 1); cycle();
    put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h308) begin n_fail++; $display("FAIL ovf_clear got %h exp 308", mem_rdata); end
    seen_tx.delete();
    tx_ready = 1;
    for (int i = 0; i < 8; i++) cycle();
    tx_ready = 0;
    n_cmp++;
    if (seen_tx.size() != 8) begin n_fail++; $display("FAIL ovf_drain_count got %0d exp 8", seen_tx.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (seen_tx[i] !== 64'(32'h100 + i)) begin
          n_fail++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, seen_tx[i], 32'h100 + i);
        end
      end
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 0", tx_valid); end
  endtask

  task automatic test_rx();
    do_reset();
    rx_valid = 1; rx_data = 64'h11; cycle();
    rx_data = 64'h22; cycle();
    rx_valid = 0;
    put(10'h110, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h11) begin n_fail++; $display("FAIL rx_peek1 got %h exp 11", mem_rdata); end
    cycle();
    n_cmp++; if (mem_rdata !== 64'h11) begin n_fail++; $display("FAIL rx_peek2 got %h exp 11", mem_rdata); end
    put(10'h118, '0, 1); cycle();
    put(10'h110, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h22) begin n_fail++; $display("FAIL rx_after_pop got %h exp 22", mem_rdata); end
    put(10'h118, '0, 1); cycle(); cycle();
    put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h20200) begin n_fail++; $display("FAIL rx_unf_status got %h exp 20200", mem_rdata); end
    put(10'h110, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h0) begin n_fail++; $display("FAIL rx_empty_read got %h exp 0", mem_rdata); end
    put(10'h100, 64'h20000, 1); cycle();
    put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h200) begin n_fail++; $display("FAIL rx_unf_clear got %h exp 200", mem_rdata); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin put(10'h108, 64'(32'h300 + i), 1); cycle(); end
    tx_ready = 1;
    for (int k = 0; k < 20; k++) begin
      put(10'h108, 64'(32'h400 + k), 1); cycle();
      n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, tx_valid); end
    end
    tx_ready = 0;
    put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h203) begin n_fail++; $display("FAIL b2b_status got %h exp 203", mem_rdata); end
    n_cmp++;
    if (seen_tx.size() != 20) begin n_fail++; $display("FAIL b2b_count got %0d exp 20", seen_tx.size()); end
    else begin
      for (int i = 0; i < 20; i++) begin
        n_cmp++;
        if (seen_tx[i] !== ((i < 3) ? 64'(32'h300 + i) : 64'(32'h400 + i - 3))) begin
          n_fail++; $display("FAIL b2b_order[%0d] got %h", i, seen_tx[i]);
        end
      end
    end
    // Fill to full, then push while the stream pops: push is dropped.
    for (int i = 0; i < 5; i++) begin put(10'h108, 64'(32'h500 + i), 1); cycle(); end
    tx_ready = 1; put(10'h108, 64'hBAD, 1); cycle();
    tx_ready = 0; put(10'h100, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== 64'h10207) begin n_fail++; $display("FAIL full_pop_status got %h exp 10207", mem_rdata); end
    cycle();
    n_cmp++; if (tx_data !== 64'h412) begin n_fail++; $display("FAIL stall_hold1 got %h exp 412", tx_data); end
    cycle();
    n_cmp++; if (tx_data !== 64'h412) begin n_fail++; $display("FAIL stall_hold2 got %h exp 412", tx_data); end
  endtask

  task automatic test_scratch();
    logic [DW-1:0] v;
    v = {$urandom, $urandom};
    put(10'h120, v, 1); cycle();
    put(10'h127, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== v) begin n_fail++; $display("FAIL scratch_rw got %h exp %h", mem_rdata, v); end
    put(10'h020, ~v, 1); cycle();
    put(10'h320, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== v) begin n_fail++; $display("FAIL scratch_nonmmio_wr got %h exp %h", mem_rdata, v); end
    put(10'h020, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== '0) begin n_fail++; $display("FAIL nonmmio_read got %h exp 0", mem_rdata); end
    put(10'h130, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== '0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", mem_rdata); end
    put(10'h108, '0, 0); cycle();
    n_cmp++; if (mem_rdata !== '0) begin n_fail++; $display("FAIL wo_read got %h exp 0", mem_rdata); end
  endtask

  task automatic test_cycles();
    logic [DW-1:0] a, b;
    put(10'h128, '0, 0); cycle();
    a = mem_rdata;
    put(10'h000, '0, 0);
    for (int i = 0; i < 4; i++) cycle();
    put(10'h128, '0, 0); cycle();
    b = mem_rdata;
`ifdef MMIO_CYCLE_COUNTER_EN
    n_cmp++; if (b - a !== 64'd5) begin n_fail++; $display("FAIL cycles_delta got %0d exp 5", b - a); end
`else
    n_cmp++; if (a !== '0) begin n_fail++; $display("FAIL cycles_absent_a got %h exp 0", a); end
    n_cmp++; if (b !== '0) begin n_fail++; $display("FAIL cycles_absent_b got %h exp 0", b); end
`endif
  endtask

  task automatic test_random();
    logic [9:0] a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) a = {2'b00, 8'($urandom)};
      else a = {2'($urandom_range(1, 3)), 5'($urandom_range(0, 6)), 3'($urandom)};
      put(a, {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) == 0);
      rx_data  = {$urandom, $urandom};
      cycle();
      n_cmp++; if (mem_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata cyc %0d addr %h got %h exp %h", c, a, mem_rdata, m_rdata); end
      n_cmp++; if (tx_valid !== (m_txq.size() != 0)) begin n_fail++; $display("FAIL rand_tx_valid cyc %0d got %b exp %b", c, tx_valid, m_txq.size() != 0); end
      n_cmp++; if (rx_ready !== (m_rxq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_rx_ready cyc %0d got %b exp %b", c, rx_ready, m_rxq.size() < DEPTH); end
      if (m_txq.size() != 0) begin
        n_cmp++; if (tx_data !== m_txq[0]) begin n_fail++; $display("FAIL rand_tx_data cyc %0d got %h exp %h", c, tx_data, m_txq[0]); end
      end
    end
    tx_ready = 0; rx_valid = 0; put(10'h000, '0, 0);
  endtask

  initial begin
    reset = 1; tx_ready = 0; rx_valid = 0; rx_data = '0;
    put(10'h000, '0, 0);
    #1;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx();
    test_back_to_back();
    test_scratch();
    test_cycles();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
